// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  localparam int unsigned PC_W_DEFAULT   = 16;
  localparam int unsigned INST_W_DEFAULT = 32;

  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  typedef enum logic {
    FS_BOOT = 1'b0,
    FS_RUN  = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [INST_W_DEFAULT-1:0] inst;
    logic [PC_W_DEFAULT-1:0]   pc;
  } fetch_bundle_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: instruction-memory read port plus the IF/ID boundary
// (stall/redirect from decode, instruction bundle to decode).
interface fetch_stage_if #(
  parameter int unsigned PC_W   = 16,
  parameter int unsigned INST_W = 32
);
  logic [PC_W-1:0]   imem_addr;
  logic              imem_rden;
  logic [INST_W-1:0] imem_q;
  logic              stall;
  logic              redirect_valid;
  logic [PC_W-1:0]   redirect_pc;
  logic [INST_W-1:0] if_inst;
  logic [PC_W-1:0]   if_pc;
  logic              if_valid;

  modport master (
    output imem_addr, imem_rden, if_inst, if_pc, if_valid,
    input  imem_q, stall, redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_addr, imem_rden, if_inst, if_pc, if_valid,
    output imem_q, stall, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry holding register: parks a fetched word while decode is stalled.
module fetch_skid_buf
  import fetch_pkg::*;
#(
  parameter type T = fetch_bundle_t
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic drain,
  input  logic clear,
  input  T     din,
  output T     dout,
  output logic valid
);

  logic valid_q, valid_d;
  T     data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clear) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      data_d  = din;
    end else if (drain) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) valid_q <= 1'b0;
    else      valid_q <= valid_d;
  end

  // Payload is only meaningful while valid_q is set, so it carries no reset.
  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign dout  = data_q;
  assign valid = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC ownership, synchronous imem reads, IF/ID register with skid.
// Optional macro FETCH_PERF_CNT_EN adds fetched/stall performance counters.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int unsigned     PC_W     = PC_W_DEFAULT,
  parameter int unsigned     INST_W   = INST_W_DEFAULT,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter logic [PC_W-1:0] PC_STEP  = PC_W'(1)
) (
  input logic           clk,
  input logic           rst,
  fetch_stage_if.master fif
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]   perf_fetched,
  output logic [31:0]   perf_stall_cycles
`endif
);

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [PC_W-1:0]   pc;
  } bundle_t;

  fetch_state_t state_q, state_d;

  logic [PC_W-1:0]   pc_q, pc_d;
  logic [PC_W-1:0]   req_pc_q, req_pc_d;
  logic              pend_q, pend_d;
  logic [INST_W-1:0] out_inst_q, out_inst_d;
  logic [PC_W-1:0]   out_pc_q, out_pc_d;
  logic              out_valid_q, out_valid_d;

  logic    issue;
  logic    skid_valid, skid_load, skid_drain, skid_clear;
  bundle_t skid_din, skid_dout;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= FS_BOOT;
    else      state_q <= state_d;
  end

  // Next state: one boot cycle, then run until reset
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FS_BOOT: state_d = FS_RUN;
      FS_RUN:  state_d = FS_RUN;
    endcase
  end

  // FSM outputs: a read is only issued when its result can be absorbed
  always_comb begin
    issue = (state_q == FS_RUN) && !fif.stall && !fif.redirect_valid && !skid_valid;
  end

  assign skid_clear = fif.redirect_valid;
  assign skid_load  = !fif.redirect_valid && fif.stall && pend_q;
  assign skid_drain = !fif.redirect_valid && !fif.stall && skid_valid;
  assign skid_din   = '{inst: fif.imem_q, pc: req_pc_q};

  fetch_skid_buf #(.T(bundle_t)) u_skid (
    .clk   (clk),
    .rst   (rst),
    .load  (skid_load),
    .drain (skid_drain),
    .clear (skid_clear),
    .din   (skid_din),
    .dout  (skid_dout),
    .valid (skid_valid)
  );

  always_comb begin
    pc_d        = pc_q;
    req_pc_d    = req_pc_q;
    pend_d      = issue;
    out_inst_d  = out_inst_q;
    out_pc_d    = out_pc_q;
    out_valid_d = out_valid_q;

    if (fif.redirect_valid) begin
      pc_d        = fif.redirect_pc;
      out_valid_d = 1'b0;
    end else begin
      if (issue) begin
        req_pc_d = pc_q;
        pc_d     = pc_q + PC_STEP;
      end
      if (!fif.stall) begin
        if (skid_valid) begin
          out_inst_d  = skid_dout.inst;
          out_pc_d    = skid_dout.pc;
          out_valid_d = 1'b1;
        end else if (pend_q) begin
          out_inst_d  = fif.imem_q;
          out_pc_d    = req_pc_q;
          out_valid_d = 1'b1;
        end else begin
          out_valid_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q        <= RESET_PC;
      req_pc_q    <= '0;
      pend_q      <= 1'b0;
      out_inst_q  <= INST_W'(NOP_INST);
      out_pc_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      req_pc_q    <= req_pc_d;
      pend_q      <= pend_d;
      out_inst_q  <= out_inst_d;
      out_pc_q    <= out_pc_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign fif.imem_addr = pc_q;
  assign fif.imem_rden = issue;
  assign fif.if_inst   = out_inst_q;
  assign fif.if_pc     = out_pc_q;
  assign fif.if_valid  = out_valid_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetched_q, fetched_d;
  logic [31:0] stall_cyc_q, stall_cyc_d;

  always_comb begin
    fetched_d   = fetched_q;
    stall_cyc_d = stall_cyc_q;
    if (out_valid_q && !fif.stall)              fetched_d   = fetched_q + 32'd1;
    if (fif.stall && (state_q == FS_RUN))       stall_cyc_d = stall_cyc_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetched_q   <= '0;
      stall_cyc_q <= '0;
    end else begin
      fetched_q   <= fetched_d;
      stall_cyc_q <= stall_cyc_d;
    end
  end

  assign perf_fetched      = fetched_q;
  assign perf_stall_cycles = stall_cyc_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a cycle-level reference model.
module tb_fetch_stage;
  import fetch_pkg::*;

  localparam int unsigned PW = 16;
  localparam int unsigned IW = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          stall;
  logic          redir_v;
  logic [PW-1:0] redir_pc;

  int n_chk = 0;
  int n_err = 0;

  fetch_stage_if #(.PC_W(PW), .INST_W(IW)) fif ();

  assign fif.stall          = stall;
  assign fif.redirect_valid = redir_v;
  assign fif.redirect_pc    = redir_pc;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_stall_cycles;
  fetch_stage dut (
    .clk               (clk),
    .rst               (rst),
    .fif               (fif),
    .perf_fetched      (perf_fetched),
    .perf_stall_cycles (perf_stall_cycles)
  );
`else
  fetch_stage dut (
    .clk (clk),
    .rst (rst),
    .fif (fif)
  );
`endif

  function automatic logic [31:0] mem_word(input logic [PW-1:0] a);
    return 32'hA000_0000 + {16'h0000, a};
  endfunction

  // Instruction memory: one-cycle read latency
  always @(posedge clk) begin
    if (fif.imem_rden) fif.imem_q <= mem_word(fif.imem_addr);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: tracks PCs only; instruction words follow from mem_word()
  logic          m_run, m_pend, m_skv, m_valid;
  logic [PW-1:0] m_pc, m_req, m_skpc, m_opc;
  logic [31:0]   m_oinst;
  logic [31:0]   m_fetched, m_stallc;
  wire           m_issue = m_run && !stall && !redir_v && !m_skv;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_run <= 1'b0; m_pend <= 1'b0; m_skv <= 1'b0; m_valid <= 1'b0;
      m_pc <= '0; m_req <= '0; m_skpc <= '0; m_opc <= '0; m_oinst <= '0;
      m_fetched <= '0; m_stallc <= '0;
    end else begin
      m_run <= 1'b1;
      if (m_valid && !stall) m_fetched <= m_fetched + 1;
      if (stall && m_run)    m_stallc  <= m_stallc + 1;
      if (redir_v) begin
        m_pc <= redir_pc; m_pend <= 1'b0; m_skv <= 1'b0; m_valid <= 1'b0;
      end else begin
        m_pend <= m_issue;
        if (m_issue) begin
          m_req <= m_pc;
          m_pc  <= m_pc + 1'b1;
        end
        if (!stall) begin
          if (m_skv) begin
            m_opc <= m_skpc; m_oinst <= mem_word(m_skpc); m_valid <= 1'b1; m_skv <= 1'b0;
          end else if (m_pend) begin
            m_opc <= m_req; m_oinst <= mem_word(m_req); m_valid <= 1'b1;
          end else begin
            m_valid <= 1'b0;
          end
        end else if (m_pend) begin
          m_skpc <= m_req; m_skv <= 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("cmp_rden",  {31'b0, fif.imem_rden}, {31'b0, m_issue});
    chk("cmp_addr",  {16'b0, fif.imem_addr}, {16'b0, m_pc});
    chk("cmp_valid", {31'b0, fif.if_valid},  {31'b0, m_valid});
    if (m_valid || !rst) begin
      chk("cmp_pc",   {16'b0, fif.if_pc}, {16'b0, m_opc});
      chk("cmp_inst", fif.if_inst, m_oinst);
    end
`ifdef FETCH_PERF_CNT_EN
    chk("cmp_perf_fetched", perf_fetched, m_fetched);
    chk("cmp_perf_stall",   perf_stall_cycles, m_stallc);
`endif
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string nm, input logic v, input logic [PW-1:0] pc);
    chk({nm, "_valid"}, {31'b0, fif.if_valid}, {31'b0, v});
    if (v) begin
      chk({nm, "_pc"},   {16'b0, fif.if_pc}, {16'b0, pc});
      chk({nm, "_inst"}, fif.if_inst, mem_word(pc));
    end
  endtask

  task automatic wait_valid_pc(input string nm, input logic [PW-1:0] pc);
    int n = 0;
    tick();
    while (!fif.if_valid && n < 4) begin
      tick();
      n++;
    end
    if (!fif.if_valid) begin
      n_chk++;
      n_err++;
      $display("FAIL %s_timeout actual=no_valid expected=pc_%h", nm, pc);
    end else begin
      expect_out(nm, 1'b1, pc);
    end
  endtask

  task automatic release_seq(input string nm);
    rst = 1'b1;
    #1;
    chk({nm, "_boot_rden"}, {31'b0, fif.imem_rden}, 32'd0);
    tick();
    chk({nm, "_run_rden"}, {31'b0, fif.imem_rden}, 32'd1);
    expect_out({nm, "_e1"}, 1'b0, '0);
    tick();
    expect_out({nm, "_e2"}, 1'b0, '0);
    tick();
    chk({nm, "_e3_inst"}, fif.if_inst, 32'hA000_0000);
    expect_out({nm, "_e3"}, 1'b1, 16'h0000);
    for (int k = 1; k <= 3; k++) begin
      tick();
      expect_out({nm, "_seq"}, 1'b1, PW'(k));
    end
  endtask

  initial begin
    stall = 1'b0; redir_v = 1'b0; redir_pc = '0;
    tick(); tick();

    chk("rst_valid", {31'b0, fif.if_valid}, 32'd0);
    chk("rst_inst",  fif.if_inst, 32'h0);
    chk("rst_pc",    {16'b0, fif.if_pc}, 32'd0);
    chk("rst_addr",  {16'b0, fif.imem_addr}, 32'd0);

    release_seq("rel");

    // Stall for three edges while pc 4 is presented
    tick();
    expect_out("pre_stall", 1'b1, 16'h0004);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      expect_out("stall_hold", 1'b1, 16'h0004);
    end
`ifdef FETCH_PERF_CNT_EN
    chk("perf_stall_3", perf_stall_cycles, 32'd3);
    chk("perf_fetched_4", perf_fetched, 32'd4);
`endif
    stall = 1'b0;
    wait_valid_pc("post_stall5", 16'h0005);
    wait_valid_pc("post_stall6", 16'h0006);
    wait_valid_pc("post_stall7", 16'h0007);

    // Redirect while streaming
    redir_v = 1'b1; redir_pc = 16'h0040;
    tick();
    redir_v = 1'b0;
    expect_out("redir_b1", 1'b0, '0);
    tick();
    expect_out("redir_b2", 1'b0, '0);
    tick();
    chk("redir_inst", fif.if_inst, 32'hA000_0040);
    expect_out("redir_t0", 1'b1, 16'h0040);
    tick();
    expect_out("redir_t1", 1'b1, 16'h0041);

    // Redirect arriving with stall asserted and the skid occupied
    stall = 1'b1;
    tick();
    expect_out("skid_fill", 1'b1, 16'h0041);
    redir_v = 1'b1; redir_pc = 16'h0010;
    tick();
    redir_v = 1'b0;
    expect_out("rs_flush", 1'b0, '0);
    tick();
    expect_out("rs_hold", 1'b0, '0);
    chk("rs_rden_stalled", {31'b0, fif.imem_rden}, 32'd0);
    stall = 1'b0;
    #1;
    chk("rs_rden_resume", {31'b0, fif.imem_rden}, 32'd1);
    chk("rs_addr", {16'b0, fif.imem_addr}, 32'h0010);
    tick();
    expect_out("rs_bubble", 1'b0, '0);
    tick();
    expect_out("rs_first", 1'b1, 16'h0010);

    // PC wrap at the top of the address space
    redir_v = 1'b1; redir_pc = 16'hFFFF;
    tick();
    redir_v = 1'b0;
    tick();
    tick();
    chk("wrap_inst_ffff", fif.if_inst, 32'hA000_FFFF);
    expect_out("wrap_ffff", 1'b1, 16'hFFFF);
    tick();
    chk("wrap_inst_0000", fif.if_inst, 32'hA000_0000);
    expect_out("wrap_0000", 1'b1, 16'h0000);

    // Asynchronous reset between edges
    #3;
    rst = 1'b0;
    #1;
    chk("arst_valid", {31'b0, fif.if_valid}, 32'd0);
    chk("arst_inst",  fif.if_inst, 32'h0);
    chk("arst_addr",  {16'b0, fif.imem_addr}, 32'd0);
    chk("arst_rden",  {31'b0, fif.imem_rden}, 32'd0);
`ifdef FETCH_PERF_CNT_EN
    chk("arst_perf_fetched", perf_fetched, 32'd0);
    chk("arst_perf_stall",   perf_stall_cycles, 32'd0);
`endif
    tick(); tick();
    release_seq("rerel");
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
